// File: rtl/rv32m_pkg.sv
// rv32m_pkg: RV32M funct3 codes, muldiv FSM states and divider iteration count
package rv32m_pkg;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;
    localparam int DIV_ITERS = 32;
    typedef enum logic [2:0] {IDLE, MUL1, DIV_RUN, DIV_FIX, DONE} state_t;
endpackage

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider on unsigned magnitudes, one quotient bit per step
module div_iter
    import rv32m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             last
);
    localparam int CW = $clog2(DIV_ITERS);
    logic [WIDTH-1:0] d;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sh, diff;
    always_comb begin
        sh = {rem, quo[WIDTH-1]};
        diff = sh - {1'b0, d};
        last = cnt == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= '0;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            d <= divisor;
            quo <= dividend;
            rem <= '0;
            cnt <= CW'(DIV_ITERS - 1);
        end else if (step) begin
            rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute unit, 2-stage multiplier plus iterative divider behind one FSM
module muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit DIV_EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    state_t state, state_n;
    logic [1:0] sel;
    logic neg_q, neg_r, dz;
    logic signed [49:0] pp_lo, pp_hi;
    logic signed [32:0] a_ext, b_ext;
    logic [63:0] prod;
    logic [WIDTH-1:0] mag1, mag2, quo, rem, spec_res, fix_res;
    logic idle_like, accept, is_mul, s1, s2, div_zero, ovf, early, last;
    always_comb begin
        idle_like = state == IDLE || state == DONE;
        accept = start && !flush && idle_like;
        is_mul = !funct3[2];
        a_ext = {funct3 != F_MULHU && op1[WIDTH-1], op1};
        b_ext = {funct3 == F_MULH && op2[WIDTH-1], op2};
        prod = 64'(pp_lo) + (64'(pp_hi) << 16);
        s1 = !funct3[0] && op1[WIDTH-1];
        s2 = !funct3[0] && op2[WIDTH-1];
        mag1 = s1 ? -op1 : op1;
        mag2 = s2 ? -op2 : op2;
        div_zero = op2 == '0;
        ovf = !funct3[0] && op1 == {1'b1, {(WIDTH-1){1'b0}}} && op2 == '1;
        early = DIV_EARLY_OUT && (div_zero || ovf);
        // the overflow quotient equals op1 itself (0x80000000)
        spec_res = funct3[1] ? (div_zero ? op1 : '0) : (div_zero ? '1 : op1);
        fix_res = sel[1] ? (neg_r ? -rem : rem) : dz ? '1 : neg_q ? -quo : quo;
        state_n = flush ? IDLE
                : idle_like ? (!accept ? IDLE : is_mul ? MUL1 : early ? DONE : DIV_RUN)
                : (state == MUL1 || state == DIV_FIX) ? DONE
                : last ? DIV_FIX : DIV_RUN;
        busy = start || !idle_like;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            pp_lo <= '0;
            pp_hi <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                sel <= funct3[1:0];
                neg_q <= s1 ^ s2;
                neg_r <= s1;
                dz <= div_zero;
                pp_lo <= 50'(a_ext) * 50'($signed({1'b0, b_ext[15:0]}));
                pp_hi <= 50'(a_ext) * 50'($signed(b_ext[32:16]));
                if (!is_mul && early) result <= spec_res;
            end
            if (state == MUL1 && !flush) result <= sel == 2'b00 ? prod[31:0] : prod[63:32];
            if (state == DIV_FIX && !flush) result <= fix_res;
        end
    end
    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk(clk),
        .rst(rst),
        .load(accept && !is_mul),
        .step(state == DIV_RUN),
        .dividend(mag1),
        .divisor(mag2),
        .quo(quo),
        .rem(rem),
        .last(last)
    );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, busy, flush and reset
module tb_muldiv_unit;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0] funct3 = 3'd0;
    logic [31:0] op1 = '0, op2 = '0;
    logic busy, done;
    logic [31:0] result;
    logic busy_at_done;
    int checks = 0, errors = 0;
    muldiv_unit #(.WIDTH(32), .DIV_EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
    );
    always #5 clk = ~clk;
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b;
        #1 bcnt = busy ? 1 : 0;
        lat = 0;
        res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0; op1 = ~a; op2 = a ^ b; funct3 = ~f;
            #1;
            if (done) begin
                res = result;
                busy_at_done = busy;
                return;
            end
            bcnt += busy ? 1 : 0;
        end
        lat = -1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h expected 00000000", result); end
        rst = 1'b0;
    endtask
    task automatic run_table(input string name, input int n, input logic [2:0] fv[8], input logic [31:0] av[8],
                             input logic [31:0] bv[8], input logic [31:0] ev[8], input int exp_lat);
        logic [31:0] res;
        int lat, bcnt;
        for (int i = 0; i < n; i++) begin
            run_op(fv[i], av[i], bv[i], res, lat, bcnt);
            checks++; if (res !== ev[i]) begin errors++; $display("FAIL %s[%0d] result: got %h expected %h", name, i, res, ev[i]); end
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, exp_lat); end
            checks++; if (bcnt !== exp_lat) begin errors++; $display("FAIL %s[%0d] busy cycles: got %0d expected %0d", name, i, bcnt, exp_lat); end
            checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL %s[%0d] busy at done: got %b expected 0", name, i, busy_at_done); end
        end
    endtask
    task automatic test_mul();
        logic [2:0]  fv[8] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        logic [31:0] av[8] = '{32'h7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 0, 0};
        logic [31:0] bv[8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h2, 32'h10, 0, 0};
        logic [31:0] ev[8] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h23456780, 0, 0};
        run_table("mul", 6, fv, av, bv, ev, 2);
    endtask
    task automatic test_div();
        logic [2:0]  fv[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd5};
        logic [31:0] av[8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd20, 32'd20, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] bv[8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h10, 32'hFFFFFFFF};
        logic [31:0] ev[8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2, 32'h0FFFFFFF, 32'h0};
        run_table("div", 8, fv, av, bv, ev, 34);
    endtask
    task automatic test_early_out();
        logic [2:0]  fv[8] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6, 0, 0};
        logic [31:0] av[8] = '{32'h12345678, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9, 0, 0};
        logic [31:0] bv[8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0};
        logic [31:0] ev[8] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 0, 0};
        run_table("early", 6, fv, av, bv, ev, 1);
    endtask
    task automatic test_ignore_start();
        int lat = 0;
        logic got = 1'b0;
        logic [31:0] res = 'x;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd3;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin got = 1'b1; res = result; break; end
            start = lat == 5; funct3 = 3'd0; op1 = 32'd1; op2 = 32'd1;
        end
        start = 1'b0;
        checks++; if (got !== 1'b1 || lat !== 34) begin errors++; $display("FAIL ignore_start latency: got %0d expected 34", lat); end
        checks++; if (res !== 32'h14D) begin errors++; $display("FAIL ignore_start result: got %h expected 0000014d", res); end
    endtask
    task automatic test_flush();
        int dseen = 0;
        logic [31:0] res;
        int lat, bcnt;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        @(negedge clk) flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush idle busy: got %b expected 0", busy); end
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dseen++;
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL flush done pulses: got %0d expected 0", dseen); end
        checks++; if (result !== 32'h14D) begin errors++; $display("FAIL flush result held: got %h expected 0000014d", result); end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op1 = 32'd2; op2 = 32'd3;
        @(posedge clk);
        @(negedge clk) begin start = 1'b0; flush = 1'b0; end
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_start discarded: got busy %b done %b expected 0 0", busy, done); end
        run_op(3'd0, 32'd6, 32'd7, res, lat, bcnt);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_after_flush result: got %h expected 0000002a", res); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mul_after_flush latency: got %0d expected 2", lat); end
    endtask
    task automatic test_rst_mid();
        int dseen = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid result: got %h expected 00000000", result); end
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dseen++;
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL rst_mid done pulses: got %0d expected 0", dseen); end
    endtask
    task automatic test_back_to_back();
        int lat = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op1 = 32'd3; op2 = 32'd5;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b mul done: got %b expected 1", done); end
        checks++; if (result !== 32'd15) begin errors++; $display("FAIL b2b mul result: got %h expected 0000000f", result); end
        start = 1'b1; funct3 = 3'd4; op1 = 32'hFFFFFF9C; op2 = 32'd7;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b start busy: got %b expected 1", busy); end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b div latency: got %0d expected 34", lat); end
        checks++; if (result !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b div result: got %h expected fffffff2", result); end
    endtask
    initial begin
        test_reset();
        test_mul();
        test_div();
        test_early_out();
        test_ignore_start();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
